// File: rtl/eae_pkg.sv
// Shared types and constants for the EAE sequencer slice.
package eae_pkg;

    localparam int unsigned WORD_W    = 12;
    localparam int unsigned NMI_LIMIT = 23;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_SCL = 3'd1,
        OP_MUY = 3'd2,
        OP_DVI = 3'd3,
        OP_NMI = 3'd4,
        OP_SHL = 3'd5,
        OP_ASR = 3'd6,
        OP_LSR = 3'd7
    } eae_op_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        NORM,
        MD_START,
        MD_WAIT,
        MD_CAPTURE,
        DONE
    } eae_state_t;

endpackage

// File: rtl/eae_shift_step.sv
// One-bit shift/normalise step over {link,AC,MQ}; purely combinational.
module eae_shift_step
    import eae_pkg::*;
(
    input  eae_op_t           op_i,
    input  logic              link_i,
    input  logic [WORD_W-1:0] ac_i,
    input  logic [WORD_W-1:0] mq_i,
    output logic              link_o,
    output logic [WORD_W-1:0] ac_o,
    output logic [WORD_W-1:0] mq_o
);

    // Select the single-bit move for the active shift opcode; others pass through.
    always_comb begin
        link_o = link_i;
        ac_o   = ac_i;
        mq_o   = mq_i;
        case (op_i)
            OP_SHL: {link_o, ac_o, mq_o} = {ac_i, mq_i, 1'b0};
            OP_ASR: begin
                link_o       = ac_i[WORD_W-1];
                {ac_o, mq_o} = {ac_i[WORD_W-1], ac_i, mq_i[WORD_W-1:1]};
            end
            OP_LSR: begin
                link_o       = 1'b0;
                {ac_o, mq_o} = {1'b0, ac_i, mq_i[WORD_W-1:1]};
            end
            OP_NMI: {ac_o, mq_o} = {ac_i[WORD_W-2:0], mq_i, 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/eae_sequencer.sv
// EAE sequencer: accepts an operation, steps shifts/normalise locally and
// hands multiply/divide to the external EAE datapath.
module eae_sequencer
    import eae_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  eae_op_t           op,
    input  logic [WORD_W-1:0] ac_in,
    input  logic [WORD_W-1:0] mq_in,
    input  logic [WORD_W-1:0] operand,
    input  logic              link_in,
    input  logic              eae_fin,
    input  logic [WORD_W-1:0] ac_mul,
    input  logic [WORD_W-1:0] mq_mul,
    input  logic [WORD_W-1:0] ac_dvi,
    input  logic [WORD_W-1:0] mq_dvi,
    input  logic              link_dvi,
    output logic              eae_start,
    output logic [WORD_W-1:0] md_out,
    output logic [WORD_W-1:0] ac_out,
    output logic [WORD_W-1:0] mq_out,
    output logic              link_out,
    output logic [4:0]        sc_out,
    output logic              busy,
    output logic              done
);

    eae_state_t        state_q, state_d;
    eae_op_t           op_q, op_d;
    logic [WORD_W-1:0] ac_q, ac_d;
    logic [WORD_W-1:0] mq_q, mq_d;
    logic [WORD_W-1:0] md_q, md_d;
    logic              link_q, link_d;
    logic [4:0]        sc_q, sc_d;

    logic              step_link;
    logic [WORD_W-1:0] step_ac;
    logic [WORD_W-1:0] step_mq;
    logic              norm_stop;

    eae_shift_step u_step (
        .op_i   (op_q),
        .link_i (link_q),
        .ac_i   (ac_q),
        .mq_i   (mq_q),
        .link_o (step_link),
        .ac_o   (step_ac),
        .mq_o   (step_mq)
    );

    assign norm_stop = (ac_q[WORD_W-1] != ac_q[WORD_W-2])
                    || ({ac_q, mq_q} == '0)
                    || ((ac_q == 12'o4000) && (mq_q == '0))
                    || (sc_q == 5'(NMI_LIMIT));

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign eae_start = (state_q == MD_START);
    assign ac_out    = ac_q;
    assign mq_out    = mq_q;
    assign md_out    = md_q;
    assign link_out  = link_q;
    assign sc_out    = sc_q;

    // Next-state and register-update decode for the sequencer FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ac_d    = ac_q;
        mq_d    = mq_q;
        md_d    = md_q;
        link_d  = link_q;
        sc_d    = sc_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    ac_d   = ac_in;
                    mq_d   = mq_in;
                    link_d = link_in;
                    md_d   = operand;
                    op_d   = op;
                    case (op)
                        OP_NOP: state_d = DONE;
                        OP_SCL: begin
                            sc_d    = operand[4:0];
                            state_d = DONE;
                        end
                        OP_MUY, OP_DVI: state_d = MD_START;
                        OP_NMI: begin
                            sc_d    = '0;
                            state_d = NORM;
                        end
                        default: begin
                            sc_d    = operand[4:0];
                            state_d = SHIFT;
                        end
                    endcase
                end
            end
            SHIFT: begin
                ac_d   = step_ac;
                mq_d   = step_mq;
                link_d = step_link;
                // The shift taken with sc=0 is the last one; sc stays at 0.
                if (sc_q == '0) begin
                    state_d = DONE;
                end else begin
                    sc_d = sc_q - 5'd1;
                end
            end
            NORM: begin
                if (norm_stop) begin
                    state_d = DONE;
                end else begin
                    ac_d = step_ac;
                    mq_d = step_mq;
                    sc_d = sc_q + 5'd1;
                end
            end
            MD_START: state_d = MD_WAIT;
            MD_WAIT: begin
                if (eae_fin) begin
                    state_d = MD_CAPTURE;
                end
            end
            MD_CAPTURE: begin
                if (op_q == OP_MUY) begin
                    ac_d   = ac_mul;
                    mq_d   = mq_mul;
                    link_d = 1'b0;
                end else begin
                    ac_d   = ac_dvi;
                    mq_d   = mq_dvi;
                    link_d = link_dvi;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and working-register flops with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            ac_q    <= '0;
            mq_q    <= '0;
            md_q    <= '0;
            link_q  <= 1'b0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ac_q    <= ac_d;
            mq_q    <= mq_d;
            md_q    <= md_d;
            link_q  <= link_d;
            sc_q    <= sc_d;
        end
    end

endmodule

// File: doc/eae_sequencer.md
EAE_SEQUENCER -- requirements
Module: eae_sequencer

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port req, input, 1: operation request; accepted only when busy=0.
REQ-004 SHALL have port op, input, 3: operation code (eae_pkg::eae_op_t): 0 NOP, 1 SCL, 2 MUY, 3 DVI, 4 NMI, 5 SHL, 6 ASR, 7 LSR.
REQ-005 SHALL have ports ac_in, mq_in, operand, inputs, 12 each, and link_in, input, 1: operands sampled on the accepting edge.
REQ-006 SHALL have port eae_fin, input, 1: multiply-finished flag from the EAE datapath.
REQ-007 SHALL have ports ac_mul, mq_mul, ac_dvi, mq_dvi, inputs, 12 each, and link_dvi, input, 1: EAE results.
REQ-008 SHALL have port eae_start, output, 1: start pulse to the multiply/divide units.
REQ-009 SHALL have port md_out, output, 12: latched operand; multiplicand/divisor to the EAE, stable while busy.
REQ-010 SHALL have ports ac_out, mq_out, outputs, 12 each, link_out, output, 1, and sc_out, output, 5: working/result registers; ac_out/mq_out also feed the EAE multiplier/dividend.
REQ-011 SHALL have port busy, output, 1, and done, output, 1: done is a one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, NORM, MD_START, MD_WAIT, MD_CAPTURE, DONE.
REQ-013 IDLE with req=1: latch ac_in, mq_in, link_in, operand into ac_out, mq_out, link_out, md_out; busy=1 from the next cycle; req while busy SHALL be ignored.
REQ-014 NOP: IDLE -> DONE; registers unchanged.
REQ-015 SCL: sc_out <= operand[4:0]; IDLE -> DONE.
REQ-016 SHL/ASR/LSR: sc_out <= operand[4:0]; exactly operand[4:0]+1 one-bit shifts, one per cycle in SHIFT; sc_out decrements after each shift and ends at 0; SHIFT -> DONE after the shift taken with sc_out=0.
REQ-017 SHL: {link,AC,MQ} shifts left, MQ[0] <= 0.
REQ-018 ASR: {AC,MQ} shifts right, AC[11] preserved; link <= AC[11] of the operand; MQ[0] discarded.
REQ-019 LSR: {AC,MQ} shifts right, AC[11] <= 0, link <= 0.
REQ-020 NMI: sc_out <= 0 on accept; in NORM each cycle, stop (-> DONE, no shift) if AC[11]!=AC[10], or {AC,MQ}=0, or (AC=4000 octal and MQ=0), or sc_out=23; else shift {AC,MQ} left one, zero fill, sc_out+1; link unchanged.
REQ-021 MUY/DVI: MD_START drives eae_start=1 for exactly one cycle; MD_WAIT holds until eae_fin=1 (MUY) or the divider result is ready (DVI, qualified by the same eae_fin); MD_CAPTURE, one cycle later, loads ac_out/mq_out from ac_mul/mq_mul (link_out<=0) or ac_dvi/mq_dvi (link_out<=link_dvi).
REQ-022 ac_out, mq_out, md_out SHALL not change between accept and MD_CAPTURE.
REQ-023 DONE: done=1 for one cycle, busy=0 in the following cycle, return to IDLE; a req coincident with DONE SHALL be ignored.
REQ-024 eae_fin outside MD_WAIT SHALL be ignored.
REQ-025 Op codes 1-7 outside range cannot occur (3-bit field); all paths SHALL reach DONE in at most 34 cycles after accept, except MUY/DVI, which are bounded only by eae_fin.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, busy=0, done=0, eae_start=0, ac_out=mq_out=md_out=0, link_out=0, sc_out=0, including mid-operation; an eae_fin arriving after reset SHALL have no effect.

Structure
REQ-027 eae_pkg SHALL hold eae_op_t (3-bit enum), the FSM state enum, NMI_LIMIT=23, and WORD_W=12.
REQ-028 One combinational sub-module, eae_shift_step, SHALL compute a single SHL/ASR/LSR/NMI step from {link,AC,MQ} and the op; the FSM and registers stay in eae_sequencer.

Verification
REQ-029 Bench SHALL cover SHL with ac=0001, mq=0000, link=0, operand=0002: three shifts -> ac=0010, mq=0000, link=0, sc=0; done 3 cycles after the accepting edge.
REQ-030 Bench SHALL cover ASR with ac=4000, mq=0000, operand=0000: -> ac=6000, mq=0000, link=1.
REQ-031 Bench SHALL cover LSR with ac=0001, mq=0000, operand=0000: -> ac=0000, mq=4000, link=0.
REQ-032 Bench SHALL cover NMI with ac=0000, mq=0001: -> ac=2000, mq=0000, sc=026 octal (22 shifts).
REQ-033 Bench SHALL cover MUY with mq=0003, operand=0005 and a model asserting eae_fin 12 cycles after eae_start: eae_start high exactly one cycle -> ac=0000, mq=0017, link=0, done one cycle after MD_CAPTURE.
REQ-034 Bench SHALL cover reset asserted in MD_WAIT, then eae_fin pulsed: outputs all 0, busy=0, no done pulse, and the next req is accepted normally.
